// File: rtl/keyload_c432_32.sv
// Serial key loader for the locked c432 netlist: shifts in a key LSB first, validates it,
// and drives keyinput only once a complete key is committed. `KEYLOAD_PARITY_EN adds per-byte parity.
module keyload_c432_32 #(
  parameter int unsigned      KEY_W = 32,
  parameter logic [KEY_W-1:0] DECOY = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_clr,
  input  logic             key_sdi,
  input  logic             key_sdv,
  output logic             key_sdr,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_ready,
  output logic             key_busy,
  output logic             key_err
);

  localparam int unsigned CNT_W = 6;
`ifdef KEYLOAD_PARITY_EN
  localparam int unsigned FRAME_LEN = KEY_W + 4;
`else
  localparam int unsigned FRAME_LEN = KEY_W;
`endif

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERR} state_t;

  state_t           state, state_nx;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic             accept_c, restart_c, par_ok_c;

`ifdef KEYLOAD_PARITY_EN
  logic [3:0] par;
  logic [3:0] par_calc_c;

  // Even parity of each received key byte
  always_comb begin
    par_calc_c = '0;
    for (int k = 0; k < 4; k++) par_calc_c[k] = ^shadow[8*k +: 8];
  end

  assign par_ok_c = (par_calc_c == par);

  // Parity bits follow the data bits and never enter shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= '0;
    end else if (key_clr || restart_c) begin
      par <= '0;
    end else if (accept_c && (cnt >= CNT_W'(KEY_W))) begin
      par <= {key_sdi, par[3:1]};
    end
  end
`else
  assign par_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus the datapath strobes; key_clr overrides everything
  always_comb begin
    state_nx  = state;
    accept_c  = 1'b0;
    restart_c = 1'b0;
    if (key_clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (key_start) begin
            state_nx  = SHIFT;
            restart_c = 1'b1;
          end
        end
        SHIFT: begin
          if (key_start) begin
            restart_c = 1'b1;
          end else if (key_sdv) begin
            accept_c = 1'b1;
            if (cnt == CNT_W'(FRAME_LEN - 1)) state_nx = CHECK;
          end
        end
        CHECK:   state_nx = par_ok_c ? DONE : ERR;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Shadow, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      cnt       <= '0;
      keyinput  <= DECOY;
      key_ready <= 1'b0;
      key_err   <= 1'b0;
      key_sdr   <= 1'b0;
      key_busy  <= 1'b0;
    end else begin
      key_sdr  <= (state_nx == SHIFT);
      key_busy <= (state_nx == SHIFT) || (state_nx == CHECK);
      if (key_clr || restart_c) begin
        shadow    <= '0;
        cnt       <= '0;
        keyinput  <= DECOY;
        key_ready <= 1'b0;
        key_err   <= 1'b0;
      end else if (accept_c) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt < CNT_W'(KEY_W)) shadow <= {key_sdi, shadow[KEY_W-1:1]};
      end else if (state == CHECK) begin
        if (par_ok_c) begin
          keyinput  <= shadow;
          key_ready <= 1'b1;
        end else begin
          key_err <= 1'b1;
          shadow  <= '0;
        end
      end
    end
  end

endmodule
